// File: rtl/xy2_address.sv
// Pixel (row,col) to Y/U/V frame-memory word address and bit position, one-cycle latency.
// Optional range check enabled by defining XY2_ADDRESS_RANGE_CHECK_EN.
module xy2_address (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
  output logic        out_valid,
  output logic        U_frame_buffer_num,
  output logic [15:0] Y_addr,
  output logic [5:0]  Y_data_pos,
  output logic [15:0] U_addr,
  output logic [7:0]  U_data_pos,
  output logic [12:0] V_addr,
  output logic [7:0]  V_data_pos,
  output logic        addr_err
);

  logic [19:0] iy, iu, wu, u_full, v_full;
  logic        oor;
  logic        fb_n;
  logic [15:0] y_addr_n, u_addr_n;
  logic [5:0]  y_pos_n;
  logic [7:0]  u_pos_n, v_pos_n;
  logic [12:0] v_addr_n;

  always_comb begin
    iy = {10'd0, row} * 20'd640 + {10'd0, col};
    iu = {11'd0, row[9:1]} * 20'd320 + {11'd0, col[9:1]};
    wu = iu >> 3;
`ifdef XY2_ADDRESS_RANGE_CHECK_EN
    oor = (row > 10'd479) || (col > 10'd639);
`else
    oor = 1'b0;
`endif
    // U plane spills past the top 4096 words of buffer 0 into buffer 1
    if (wu < 20'd4096) begin
      fb_n   = 1'b0;
      u_full = 20'd61440 + wu;
    end else begin
      fb_n   = 1'b1;
      u_full = wu - 20'd4096;
    end
    v_full   = 20'd3128 + (iu >> 4);
    y_addr_n = 16'(iy >> 3);
    y_pos_n  = {iy[2:0], 3'b000};
    u_addr_n = 16'(u_full);
    u_pos_n  = {2'b00, iu[2:0], 3'b000};
    v_addr_n = 13'(v_full);
    v_pos_n  = {1'b0, iu[3:0], 3'b000};
    if (oor) begin
      fb_n     = 1'b0;
      y_addr_n = '0;
      y_pos_n  = '0;
      u_addr_n = '0;
      u_pos_n  = '0;
      v_addr_n = '0;
      v_pos_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid          <= 1'b0;
      U_frame_buffer_num <= 1'b0;
      Y_addr             <= '0;
      Y_data_pos         <= '0;
      U_addr             <= '0;
      U_data_pos         <= '0;
      V_addr             <= '0;
      V_data_pos         <= '0;
      addr_err           <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        U_frame_buffer_num <= fb_n;
        Y_addr             <= y_addr_n;
        Y_data_pos         <= y_pos_n;
        U_addr             <= u_addr_n;
        U_data_pos         <= u_pos_n;
        V_addr             <= v_addr_n;
        V_data_pos         <= v_pos_n;
        addr_err           <= oor;
      end
    end
  end

endmodule

// File: tb/tb_xy2_address.sv
// Self-checking bench for xy2_address: directed vectors, streaming scoreboard, hold, async reset, range.
// Honours XY2_ADDRESS_RANGE_CHECK_EN when defined at compile time.
module tb_xy2_address;

  typedef struct packed {
    logic        v;
    logic        err;
    logic        fb;
    logic [15:0] ya;
    logic [5:0]  yp;
    logic [15:0] ua;
    logic [7:0]  up;
    logic [12:0] va;
    logic [7:0]  vp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  row = '0;
  logic [9:0]  col = '0;
  logic        out_valid, U_frame_buffer_num, addr_err;
  logic [15:0] Y_addr, U_addr;
  logic [5:0]  Y_data_pos;
  logic [7:0]  U_data_pos, V_data_pos;
  logic [12:0] V_addr;
  res_t        got;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t q[$];
  res_t last = '0;

  xy2_address dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .row(row), .col(col),
    .out_valid(out_valid), .U_frame_buffer_num(U_frame_buffer_num),
    .Y_addr(Y_addr), .Y_data_pos(Y_data_pos), .U_addr(U_addr), .U_data_pos(U_data_pos),
    .V_addr(V_addr), .V_data_pos(V_data_pos), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  always_comb got = {out_valid, addr_err, U_frame_buffer_num, Y_addr, Y_data_pos,
                     U_addr, U_data_pos, V_addr, V_data_pos};

  // Reference computed with integer divide/modulo from the frame layout.
  function automatic res_t model(input int r, input int c);
    res_t e;
    int iy, iu, wu;
    e = '0;
    e.v = 1'b1;
`ifdef XY2_ADDRESS_RANGE_CHECK_EN
    if (r > 479 || c > 639) begin
      e.err = 1'b1;
      return e;
    end
`endif
    iy = r * 640 + c;
    iu = (r / 2) * 320 + (c / 2);
    wu = iu / 8;
    e.ya = 16'(iy / 8);
    e.yp = 6'((iy % 8) * 8);
    e.up = 8'((iu % 8) * 8);
    if (wu < 4096) begin
      e.fb = 1'b0;
      e.ua = 16'(61440 + wu);
    end else begin
      e.fb = 1'b1;
      e.ua = 16'(wu - 4096);
    end
    e.va = 13'(3128 + iu / 16);
    e.vp = 8'((iu % 16) * 8);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; row = 10'd100; col = 10'd200;
    #1;
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL reset_initial got=%h exp=0", got);
    end
    step(); step();
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL reset_held_with_clk got=%h exp=0", got);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL reset_release_idle got=%h exp=0", got);
    end
  endtask

  task automatic test_directed();
    int   rows [5] = '{0, 0, 204, 205, 479};
    int   cols [5] = '{0, 13, 256, 257, 639};
    res_t exps [5];
    res_t e;
    exps[0] = '{1'b1, 1'b0, 1'b0, 16'd0,     6'd0,  16'd61440, 8'd0,  13'd3128, 8'd0};
    exps[1] = '{1'b1, 1'b0, 1'b0, 16'd1,     6'd40, 16'd61440, 8'd48, 13'd3128, 8'd48};
    exps[2] = '{1'b1, 1'b0, 1'b1, 16'd16352, 6'd0,  16'd0,     8'd0,  13'd5176, 8'd0};
    exps[3] = '{1'b1, 1'b0, 1'b1, 16'd16432, 6'd8,  16'd0,     8'd0,  13'd5176, 8'd0};
    exps[4] = '{1'b1, 1'b0, 1'b1, 16'd38399, 6'd56, 16'd5503,  8'd56, 13'd7927, 8'd120};
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; row = 10'(rows[i]); col = 10'(cols[i]);
      q.push_back(exps[i]);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || q.size() == 0) begin
        n_errors++;
        $display("FAIL directed_valid[%0d] got=%b exp=1", i, out_valid);
      end else begin
        e = q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL directed[%0d] row=%0d col=%0d got=%h exp=%h", i, rows[i], cols[i], got, e);
        end
        last = e;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    res_t e;
    logic pushed;
    for (int i = 0; i < 300; i++) begin
      pushed = ($urandom_range(0, 3) != 0);
      in_valid = pushed;
      row = 10'($urandom_range(0, 479));
      col = 10'($urandom_range(0, 639));
      if (i % 50 == 0) begin row = 10'd479; col = 10'd639; end
      if (pushed) q.push_back(model(int'(row), int'(col)));
      step();
      n_checks++;
      if (out_valid !== pushed) begin
        n_errors++;
        $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, pushed);
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_underflow[%0d] got=%h exp=none", i, got);
        end else begin
          e = q.pop_front();
          n_checks++;
          if (got !== e) begin
            n_errors++;
            $display("FAIL stream[%0d] got=%h exp=%h", i, got, e);
          end
          last = e;
        end
      end else begin
        if (pushed) void'(q.pop_front());
        n_checks++;
        if (got[68:0] !== last[68:0]) begin
          n_errors++;
          $display("FAIL stream_hold[%0d] got=%h exp=%h", i, got[68:0], last[68:0]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; row = 10'(i * 37); col = 10'(i * 91);
      step();
      n_checks++;
      if (got !== {1'b0, last[68:0]}) begin
        n_errors++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, got, {1'b0, last[68:0]});
      end
    end
  endtask

  task automatic test_async_reset();
    res_t e;
    in_valid = 1'b1; row = 10'd300; col = 10'd500;
    step();
    in_valid = 1'b1; row = 10'd301; col = 10'd501;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=0", got);
    end
    q.delete();
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL reset_discard got=%h exp=0", got);
    end
    in_valid = 1'b1; row = 10'd1; col = 10'd2;
    q.push_back(model(1, 2));
    step();
    in_valid = 1'b0;
    e = q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL post_reset_first got=%h exp=%h", got, e);
    end
    last = e;
  endtask

  task automatic test_range();
    res_t e;
    logic exp_err;
`ifdef XY2_ADDRESS_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    in_valid = 1'b1; row = 10'd480; col = 10'd0;
    q.push_back(model(480, 0));
    step();
    e = q.pop_front();
    n_checks++;
    if (addr_err !== exp_err || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL range_err got=%b/%b exp=%b/1", addr_err, out_valid, exp_err);
    end
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL range_row480 got=%h exp=%h", got, e);
    end
    in_valid = 1'b1; row = 10'd1023; col = 10'd1023;
    q.push_back(model(1023, 1023));
    step();
    in_valid = 1'b0;
    e = q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL range_max got=%h exp=%h", got, e);
    end
    in_valid = 1'b1; row = 10'd2; col = 10'd4;
    q.push_back(model(2, 4));
    step();
    in_valid = 1'b0;
    e = q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_errors++;
      $display("FAIL range_recover got=%h exp=%h", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_hold();
    test_async_reset();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
